mul_sequencer: RTL and testbench

Iterative multi-cycle multiply unit with its own control FSM. Executes MUL, UMULL and SMULL using the ALUControl codes that decode produces (101, 110, 111). It sits beside the ALU. The main FSM pulses start, then holds its execute state while busy is high. Products are produced by a radix-2 shift-add over WIDTH cycles, followed by one sign-fix cycle.

---
 rtl/mul_pkg.sv | 29 ++
 rtl/mul_shift_add_dp.sv | 65 ++++++
 rtl/mul_sequencer.sv | 124 ++++++++++++
 tb/tb_mul_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiply unit: opcodes, FSM states
// and small helpers used by the sequencer and its datapath.
package mul_pkg;

    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_UMULL = 3'b110;
    localparam logic [2:0] OP_SMULL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // Iteration counter width; kept at least 1 bit so WIDTH=1 still elaborates.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic logic op_valid(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL);
    endfunction

    function automatic logic op_long(input logic [2:0] op);
        return (op == OP_UMULL) || (op == OP_SMULL);
    endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Radix-2 shift-add datapath: multiplicand, {carry, hi, lo} accumulator with
// the multiplier shifting out of lo, and the final 2W-bit conditional negate.
module mul_shift_add_dp
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    output logic [2*WIDTH-1:0] prod
);

    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             neg;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    acc;

    // Absolute value on signed ops; the most negative value maps onto itself,
    // which reads correctly as an unsigned magnitude.
    always_comb begin
        mag_a = srca;
        mag_b = srcb;
        if (is_signed && srca[WIDTH-1]) mag_a = ~srca + WIDTH'(1);
        if (is_signed && srcb[WIDTH-1]) mag_b = ~srcb + WIDTH'(1);
    end

    always_comb begin
        addend = lo[0] ? mcand : '0;
        sum    = {1'b0, hi} + {1'b0, addend};
        acc    = {hi, lo};
        prod   = neg ? (~acc + PW'(1)) : acc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            neg   <= 1'b0;
        end else if (load) begin
            mcand <= mag_a;
            hi    <= '0;
            lo    <= mag_b;
            neg   <= is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
        end else if (step) begin
            // Carry drops into hi's MSB; low product bits replace the multiplier.
            hi <= sum[WIDTH:1];
            lo <= {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL/UMULL/SMULL unit: control FSM, iteration counter and
// registered result/flag outputs around the shift-add datapath.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int CW = cnt_w(WIDTH);

    state_t              state;
    state_t              nstate;
    logic [CW-1:0]       cnt;
    logic [2:0]          op_q;
    logic                load;
    logic                step;
    logic                fix;
    logic                accept;
    logic                last;
    logic [2*WIDTH-1:0]  prod;

    assign accept = start && op_valid(op);
    assign last   = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        load   = 1'b0;
        step   = 1'b0;
        fix    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    load   = 1'b1;
                    nstate = S_CALC;
                end
            end
            S_CALC: begin
                step = 1'b1;
                if (last) nstate = S_FIX;
            end
            S_FIX: begin
                fix    = 1'b1;
                nstate = S_DONE;
            end
            S_DONE: begin
                // A new request in the done cycle chains straight into CALC.
                if (accept) begin
                    load   = 1'b1;
                    nstate = S_CALC;
                end else begin
                    nstate = S_IDLE;
                end
            end
            default: nstate = S_IDLE;
        endcase
    end

    assign busy = (state == S_CALC) || (state == S_FIX);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            op_q <= '0;
        end else if (load) begin
            cnt  <= '0;
            op_q <= op;
        end else if (step) begin
            cnt  <= cnt + CW'(1);
        end
    end

    mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .is_signed (op == OP_SMULL),
        .srca      (srca),
        .srcb      (srcb),
        .prod      (prod)
    );

    // Results only move in FIX, so they hold through the next CALC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_lo <= '0;
            result_hi <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
        end else if (fix) begin
            if (op_long(op_q)) begin
                result_lo <= prod[WIDTH-1:0];
                result_hi <= prod[2*WIDTH-1:WIDTH];
                flag_n    <= prod[2*WIDTH-1];
                flag_z    <= (prod == '0);
            end else begin
                result_lo <= prod[WIDTH-1:0];
                result_hi <= '0;
                flag_n    <= prod[WIDTH-1];
                flag_z    <= (prod[WIDTH-1:0] == '0);
            end
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: latency, MUL/UMULL/SMULL products and
// flags, ignored restarts/invalid ops, back-to-back starts and async abort.
module tb_mul_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] srca = '0;
    logic [W-1:0] srcb = '0;
    logic         busy, done, flag_n, flag_z;
    logic [W-1:0] result_lo, result_hi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .op        (op),
        .srca      (srca),
        .srcb      (srcb),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .flag_n    (flag_n),
        .flag_z    (flag_z)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Launch one op and wait for done. Returns edges from accept to done
    // (100 on timeout), whether busy dropped early, and whether the outputs
    // moved before done. rp >= 0 re-pulses start with new operands mid-CALC.
    task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int rp, output int lat, output int busy_bad, output int held_bad);
        logic [W-1:0] lo0, hi0;
        logic         n0, z0;
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b;
        lo0 = result_lo; hi0 = result_hi; n0 = flag_n; z0 = flag_z;
        @(posedge clk); #1;
        start = 1'b0;
        srca = ~a; srcb = ~b;
        lat = 0; busy_bad = 0; held_bad = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_bad++;
            if (lat < W && {result_lo, result_hi, flag_n, flag_z} !== {lo0, hi0, n0, z0}) held_bad++;
            if (lat == rp) begin
                start = 1'b1; op = 3'b101; srca = 32'd5; srcb = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
    endtask

    initial begin
        int lat, bb, hb, seen;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lo", result_lo, 0);
        chk("rst_hi", result_hi, 0);
        chk("rst_nz", {flag_n, flag_z}, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // MUL 7*6
        run(3'b101, 32'd7, 32'd6, -1, lat, bb, hb);
        chk("mul_lat", lat, 33);
        chk("mul_busy", bb, 0);
        chk("mul_held", hb, 0);
        chk("mul_lo", result_lo, 32'h0000002A);
        chk("mul_hi", result_hi, 0);
        chk("mul_nz", {flag_n, flag_z}, 2'b00);
        @(posedge clk); #1;
        chk("done_1cyc", done, 0);
        repeat (2) @(negedge clk);

        // UMULL max*max
        run(3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, lat, bb, hb);
        chk("umull_lat", lat, 33);
        chk("umull_prod", {result_hi, result_lo}, 64'hFFFFFFFE_00000001);
        chk("umull_nz", {flag_n, flag_z}, 2'b10);
        repeat (2) @(negedge clk);

        // SMULL min*2
        run(3'b111, 32'h80000000, 32'd2, -1, lat, bb, hb);
        chk("smull_min_prod", {result_hi, result_lo}, 64'hFFFFFFFF_00000000);
        chk("smull_min_nz", {flag_n, flag_z}, 2'b10);
        repeat (2) @(negedge clk);

        // SMULL -1*-1
        run(3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, lat, bb, hb);
        chk("smull_m1_prod", {result_hi, result_lo}, 64'h00000000_00000001);
        chk("smull_m1_nz", {flag_n, flag_z}, 2'b00);
        repeat (2) @(negedge clk);

        // UMULL 0 x 0x12345678 with a restart attempt mid-CALC
        run(3'b110, 32'd0, 32'h12345678, 5, lat, bb, hb);
        chk("rp_lat", lat, 33);
        chk("rp_busy", bb, 0);
        chk("rp_held", hb, 0);
        chk("rp_prod", {result_hi, result_lo}, 64'h0);
        chk("rp_nz", {flag_n, flag_z}, 2'b01);
        repeat (2) @(negedge clk);

        // Invalid op in IDLE is ignored
        start = 1'b1; op = 3'b011; srca = 32'd9; srcb = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        chk("inv_busy", busy, 0);
        @(posedge clk); #1;
        chk("inv_done", done, 0);

        // UMULL 0x10000^2, then MUL 3*5 started in its done cycle
        run(3'b110, 32'h00010000, 32'h00010000, -1, lat, bb, hb);
        chk("b2b_a_prod", {result_hi, result_lo}, 64'h00000001_00000000);
        run(3'b101, 32'd3, 32'd5, -1, lat, bb, hb);
        chk("b2b_b_lat", lat, 33);
        chk("b2b_b_busy", bb, 0);
        chk("b2b_b_lo", result_lo, 32'd15);
        chk("b2b_b_hi", result_hi, 0);
        chk("b2b_b_nz", {flag_n, flag_z}, 2'b00);

        // Third op aborted by reset at CALC cycle 10
        @(negedge clk);
        start = 1'b1; op = 3'b110; srca = 32'd123; srcb = 32'd456;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("abort_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_res", {result_hi, result_lo, flag_n, flag_z}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_res_hold", {result_hi, result_lo}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
